// File: rtl/remme_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : remme_pkg                                                  |
// | Description : Shared constants and state encoding for the remme encoder. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package remme_pkg;

   localparam int SYM_W = 4;
   localparam logic [SYM_W-1:0] REPEAT_CODE = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LIT  = 2'd1,
      RPT  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/remme_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : remme_fifo                                                 |
// | Description : Synchronous FIFO with wrap-bit pointers and a              |
// |               show-ahead read port.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module remme_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q;
   logic [AW:0]      rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign data_o  = mem_q[rptr_q[AW-1:0]];

   // Pointer update; the extra MSB separates full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (w_push) wptr_q <= wptr_q + 1'b1;
         if (w_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/remme_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : remme_enc                                                  |
// | Description : Remember-me transmit encoder. Buffers raw 4-bit symbols    |
// |               and emits a literal or the repeat code 4'hF each cycle.    |
// |               Define REMME_ENC_STATS_EN to add literal/repeat counters.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module remme_enc
   import remme_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int MAX_RUN = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SYM_W-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   output logic [SYM_W-1:0] r,
   output logic             r_valid,
`ifdef REMME_ENC_STATS_EN
   output logic [15:0]      lit_cnt,
   output logic [15:0]      rpt_cnt,
`endif
   output logic             err
);

   localparam logic [3:0] RUN_LIMIT = 4'(MAX_RUN);

   state_e           state_q, state_d;
   logic [SYM_W-1:0] prev_q, prev_d;
   logic [3:0]       run_q, run_d;
   logic [SYM_W-1:0] r_q, r_d;
   logic             r_valid_q, r_valid_d;
   logic             err_q;
   logic             w_full, w_empty, w_push, w_pop;
   logic [SYM_W-1:0] w_head;
   logic             w_emit_lit, w_emit_rpt;

   // Illegal 4'hF input is consumed (handshake completes) but never stored.
   assign d_ready = !w_full;
   assign w_push  = d_valid && !w_full && (d != REPEAT_CODE);
   assign w_pop   = !w_empty;

   remme_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (SYM_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (w_push),
      .data_i  (d),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Next-state and next-code decision for the symbol popped this cycle.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      run_d      = run_q;
      r_d        = '0;
      r_valid_d  = 1'b0;
      w_emit_lit = 1'b0;
      w_emit_rpt = 1'b0;
      if (w_pop) begin
         r_valid_d = 1'b1;
         if (state_q == IDLE || w_head != prev_q || run_q == RUN_LIMIT) begin
            w_emit_lit = 1'b1;
            r_d        = w_head;
            prev_d     = w_head;
            run_d      = '0;
            state_d    = LIT;
         end else begin
            w_emit_rpt = 1'b1;
            r_d        = REPEAT_CODE;
            run_d      = run_q + 1'b1;
            state_d    = RPT;
         end
      end
   end

   // State, history and registered output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         run_q     <= '0;
         r_q       <= '0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         r_q       <= r_d;
         r_valid_q <= r_valid_d;
         err_q     <= d_valid && d_ready && (d == REPEAT_CODE);
      end
   end

   assign r       = r_q;
   assign r_valid = r_valid_q;
   assign err     = err_q;

`ifdef REMME_ENC_STATS_EN
   logic [15:0] lit_cnt_q;
   logic [15:0] rpt_cnt_q;

   // Saturating counts of emitted literal and repeat codes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lit_cnt_q <= '0;
         rpt_cnt_q <= '0;
      end else begin
         if (w_emit_lit && lit_cnt_q != 16'hFFFF) lit_cnt_q <= lit_cnt_q + 1'b1;
         if (w_emit_rpt && rpt_cnt_q != 16'hFFFF) rpt_cnt_q <= rpt_cnt_q + 1'b1;
      end
   end

   assign lit_cnt = lit_cnt_q;
   assign rpt_cnt = rpt_cnt_q;
`endif

endmodule
`default_nettype wire
